// File: rtl/mul_div_hilo_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Covers the operation codes, the FSM states and the divide-by-zero result.
package mul_div_hilo_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        RUN  = 2'b10,
        FIX  = 2'b11
    } state_t;

    // Quotient reported for a zero divisor; the top truncates it to WIDTH.
    localparam logic [63:0] DIV0_QUOT = '1;

    function automatic logic is_signed_op(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mul_div_hilo_paso.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: shift-add into {acc, shreg}. Divide: restoring step that shifts quotient bits into shreg.
module mul_div_paso
    import mul_div_hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] shreg_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_shift;
    logic           div_ge;

    always_comb begin
        sum        = {1'b0, acc} + {1'b0, operand};
        rem_shift  = {acc, shreg[WIDTH-1]};
        div_ge     = rem_shift >= {1'b0, operand};
        acc_next   = acc;
        shreg_next = shreg;
        if (div_mode) begin
            // The partial remainder stays below the divisor, so WIDTH bits hold it.
            if (div_ge) begin
                acc_next   = WIDTH'(rem_shift - {1'b0, operand});
                shreg_next = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next   = rem_shift[WIDTH-1:0];
                shreg_next = {shreg[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (shreg[0]) begin
                {acc_next, shreg_next} = {sum, shreg[WIDTH-1:1]};
            end else begin
                {acc_next, shreg_next} = {1'b0, acc, shreg[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mul_div_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Handshake: start is taken only while busy=0; busy is high from the start edge until the done cycle, and done pulses once when HI/LO update.
module mul_div_hilo
    import mul_div_hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    count;
    op_t              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc, shreg, mcand;
    logic [WIDTH-1:0] acc_nx, shreg_nx;
    logic             neg_q, rneg_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = PREP;
            PREP: state_nx = RUN;
            RUN:  if (count == LAST) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        a_neg = is_signed_op(op_q) & a_q[WIDTH-1];
        b_neg = is_signed_op(op_q) & b_q[WIDTH-1];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
    end

    mul_div_paso #(.WIDTH(WIDTH)) u_paso (
        .div_mode   (op_q[1]),
        .acc        (acc),
        .shreg      (shreg),
        .operand    (mcand),
        .acc_next   (acc_nx),
        .shreg_next (shreg_nx)
    );

    // Sign correction and the zero-divisor override applied on the FIX edge.
    always_comb begin
        prod = neg_q ? -{acc, shreg} : {acc, shreg};
        {fix_hi, fix_lo} = prod;
        if (op_q[1]) begin
            if (b_q == '0) begin
                fix_hi = a_q;
                fix_lo = WIDTH'(DIV0_QUOT);
            end else begin
                fix_hi = rneg_q ? -acc : acc;
                fix_lo = neg_q ? -shreg : shreg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            op_q   <= OP_MULT;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            shreg  <= '0;
            mcand  <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op_t'(op);
                    end
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                end
                PREP: begin
                    acc    <= '0;
                    shreg  <= a_mag;
                    mcand  <= b_mag;
                    neg_q  <= a_neg ^ b_neg;
                    rneg_q <= a_neg;
                    count  <= '0;
                end
                RUN: begin
                    acc   <= acc_nx;
                    shreg <= shreg_nx;
                    count <= count + CW'(1);
                end
                FIX: begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul_div_hilo.md
Name: mul_div_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, directly downstream of the register bank.
- Consumes the two read-port words (rs on DR1, rt on DR2) for MULT/MULTU/DIV/DIVU.
- Holds 64-bit results in HI/LO for MFHI/MFLO, and accepts MTHI/MTLO writes.
- The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32: operand width. Latency derives from it.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin operation; sampled only when busy=0
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs operand (register bank DR1)
- b  input  WIDTH  rt operand (register bank DR2)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO are updated
- hi  output  WIDTH  HI register (product high / remainder)
- lo  output  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. An in-flight operation is discarded.
- FSM states:
  - IDLE: busy=0. start=1 → latch a, b, op; go to PREP.
  - PREP: take magnitudes for signed ops; record result signs; go to RUN with count=0.
  - RUN: one iteration per cycle, WIDTH cycles; count=WIDTH-1 → FIX.
  - FIX: apply sign correction; write hi/lo; assert done for one cycle; go to IDLE.
- Latency and handshake:
  - start sampled at edge 0 → hi/lo and done valid after edge WIDTH+2 (34 for WIDTH=32).
  - busy=1 from edge 0 to edge WIDTH+2; busy falls in the same cycle done rises.
  - A new start may be sampled in the cycle done=1 (back-to-back issue).
- Multiply:
  - Shift-add on magnitudes; 2·WIDTH product, {hi,lo}.
  - MULT negates the product if sign(a)≠sign(b).
  - MULTU treats operands as unsigned.
- Divide:
  - Restoring division on magnitudes; lo=quotient, hi=remainder.
  - DIV: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - b=0: same latency; lo = all ones, hi = a (unmodified dividend), for both DIV and DIVU.
  - DIV of most-negative by −1: lo=0x80000000, hi=0, no trap.
- Operand isolation: a, b, op are used only at the start edge; later changes have no effect.
- start while busy=1: ignored, no queuing.
- hi_we/lo_we while busy=1: ignored.
- hi_we/lo_we while busy=0: wdata written at that edge. Both set writes the same wdata to both.
- start with hi_we in the same IDLE cycle: both accepted. The written value is visible until FIX overwrites it.
- done is never high while start is being accepted in the same state, except for the back-to-back case above.

Decomposition:
- Shared package holds:
  - WIDTH default
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
  - FSM state encodings IDLE/PREP/RUN/FIX
  - div-by-zero quotient constant
- Sub-module mul_div_paso: combinational single iteration.
  - Inputs: mode, partial accumulator, operand.
  - Outputs: next accumulator and next shift register, for either add-shift or subtract-restore.
  - The top holds the FSM, counter, sign flags, and HI/LO.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 34 cycles hi=0xFFFFFFFE, lo=0x00000001; done high exactly one cycle; busy low same cycle.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIVU a=100, b=7 → lo=14, hi=2. DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Boundary divides:
  - DIV a=5, b=0 → lo=0xFFFFFFFF, hi=5 after 34 cycles.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Start MULTU 3×4, then mid-RUN:
  - pulse start with DIV;
  - change a/b;
  - pulse hi_we with wdata=0xDEAD;
  - → all ignored; final hi=0, lo=12.
  - Then in IDLE, lo_we with wdata=0x1234 → lo=0x1234 next cycle.
- Assert rst at cycle 10 of a RUN → hi=lo=0, busy=0, done=0 immediately (before next clk edge). After release, DIVU 9/3 completes with lo=3, hi=0.
- Back-to-back: issue MULTU 2×3, then start MULTU 5×5 in the done cycle → second done 34 cycles later with lo=25.
